// File: rtl/armleocpu_mem_fifo_pkg.sv
// Shared constants for the memory-backed FIFO and its storage block.
// Only default parameter values live here; each instance still sizes itself
// through its own module parameters.
package armleocpu_mem_fifo_pkg;

   localparam int DEFAULT_DEPTH_LOG2 = 4;
   localparam int DEFAULT_WIDTH      = 32;

endpackage : armleocpu_mem_fifo_pkg

// File: rtl/armleocpu_1r1w.sv
// Simple dual-port storage: one write port and one read port.
// The read port is registered, so data appears one cycle after a read is
// issued. The read register holds its value whenever no read is issued.
// Storage contents are intentionally never reset.
module armleocpu_1r1w
   import armleocpu_mem_fifo_pkg::*;
#(
   parameter int ELEMENTS_W = DEFAULT_DEPTH_LOG2,
   parameter int WIDTH      = DEFAULT_WIDTH
) (
   input  logic                  clk,

   input  logic                  readenable,
   input  logic [ELEMENTS_W-1:0] readaddress,
   output logic [WIDTH-1:0]      readdata,

   input  logic                  writeenable,
   input  logic [ELEMENTS_W-1:0] writeaddress,
   input  logic [WIDTH-1:0]      writedata
);

   localparam int ELEMENTS = 2 ** ELEMENTS_W;

   logic [WIDTH-1:0] storage [0:ELEMENTS-1];

   // Write port: store the payload at the write address when enabled.
   always_ff @(posedge clk) begin
      if (writeenable) begin
         storage[writeaddress] <= writedata;
      end
   end

   // Read port: capture the addressed entry into the output register only
   // on an issued read, so the output stays stable otherwise.
   always_ff @(posedge clk) begin
      if (readenable) begin
         readdata <= storage[readaddress];
      end
   end

endmodule : armleocpu_1r1w

// File: rtl/armleocpu_mem_fifo.sv
// Memory-backed FIFO with a registered read port.
// Entries sit in a 1R1W memory; the memory's read register doubles as the
// output stage, giving a total capacity of ELEMENTS + 1. in_ready depends
// only on registered state, which keeps the producer path free of any
// combinational dependence on out_ready.
module armleocpu_mem_fifo
   import armleocpu_mem_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
   parameter int WIDTH      = DEFAULT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  in_ready,

   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   input  logic                  out_ready,

   output logic [DEPTH_LOG2:0]   count
);

   localparam int                ELEMENTS     = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] ELEMENTS_CNT = ELEMENTS[DEPTH_LOG2:0];

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   mem_count;

   logic [DEPTH_LOG2-1:0] wr_ptr_nxt;
   logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
   logic [DEPTH_LOG2:0]   mem_count_nxt;
   logic                  out_valid_nxt;

   logic                  push;
   logic                  pop;
   logic                  read_issue;
   logic                  mem_write;
   logic                  mem_read;

   // Handshake decode. A read is issued whenever memory holds data and the
   // output register is empty or being drained this cycle.
   always_comb begin
      in_ready   = (mem_count < ELEMENTS_CNT);
      push       = in_valid && in_ready;
      pop        = out_valid && out_ready;
      read_issue = (mem_count != '0) && (!out_valid || out_ready);
      // Nothing may touch the memory or its read register in a reset cycle,
      // so an in-flight read is dropped along with every stored entry.
      mem_write  = push && rst_n;
      mem_read   = read_issue && rst_n;
   end

   // Next-state computation for pointers, occupancy and the output flag.
   always_comb begin
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      mem_count_nxt = mem_count;
      out_valid_nxt = out_valid;

      if (push) begin
         wr_ptr_nxt = wr_ptr + 1'b1;
      end

      if (read_issue) begin
         rd_ptr_nxt = rd_ptr + 1'b1;
      end

      case ({push, read_issue})
         2'b10:   mem_count_nxt = mem_count + 1'b1;
         2'b01:   mem_count_nxt = mem_count - 1'b1;
         default: mem_count_nxt = mem_count;
      endcase

      if (read_issue) begin
         out_valid_nxt = 1'b1;
      end else if (pop) begin
         out_valid_nxt = 1'b0;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         out_valid <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         mem_count <= mem_count_nxt;
         out_valid <= out_valid_nxt;
      end
   end

   // Occupancy seen from outside includes the entry parked in the read register.
   always_comb begin
      count = mem_count + {{DEPTH_LOG2{1'b0}}, out_valid};
   end

   // Read and write addresses never collide: a read needs mem_count > 0 and a
   // write needs mem_count < ELEMENTS, so no bypass path is required.
   armleocpu_1r1w #(
      .ELEMENTS_W (DEPTH_LOG2),
      .WIDTH      (WIDTH)
   ) u_storage (
      .clk          (clk),
      .readenable   (mem_read),
      .readaddress  (rd_ptr),
      .readdata     (out_data),
      .writeenable  (mem_write),
      .writeaddress (wr_ptr),
      .writedata    (in_data)
   );

endmodule : armleocpu_mem_fifo

// File: tb/tb_armleocpu_mem_fifo.sv
// Self-checking bench for armleocpu_mem_fifo with a data scoreboard and a
// small occupancy model of the FIFO.
module tb_armleocpu_mem_fifo;

   localparam int DEPTH_LOG2 = 4;
   localparam int WIDTH      = 32;
   localparam int ELEMENTS   = 2 ** DEPTH_LOG2;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic [WIDTH-1:0]    in_data;
   logic                in_ready;
   logic                out_valid;
   logic [WIDTH-1:0]    out_data;
   logic                out_ready;
   logic [DEPTH_LOG2:0] count;

   int checks = 0;
   int errors = 0;

   // Model state: entries waiting in memory, output register flag, and
   // every accepted entry in arrival order.
   int               m_mem_count;
   logic             m_out_valid;
   logic [WIDTH-1:0] sb [$];
   int               n_popped;

   armleocpu_mem_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mem_count = 0;
      m_out_valid = 1'b0;
      sb.delete();
   endtask

   // One reset cycle with arbitrary handshake inputs held active.
   task automatic apply_reset(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
      rst_n     = 1'b0;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock cycle: drive inputs, compare outputs against the model,
   // then advance the model with the same handshake the DUT sees.
   task automatic apply_stimulus(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                                 output logic accepted);
      logic m_push;
      logic m_read;
      logic m_pop;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      check_output("in_ready", 32'(in_ready), (m_mem_count < ELEMENTS) ? 32'd1 : 32'd0);
      check_output("out_valid", 32'(out_valid), 32'(m_out_valid));
      check_output("count", 32'(count), 32'(m_mem_count + int'(m_out_valid)));
      if (m_out_valid) begin
         if (sb.size() == 0) begin
            check_output("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            check_output("out_data", out_data, sb[0]);
         end
      end
      m_push = iv && (m_mem_count < ELEMENTS);
      m_read = (m_mem_count > 0) && (!m_out_valid || ordy);
      m_pop  = m_out_valid && ordy;
      if (m_pop && sb.size() > 0) begin
         void'(sb.pop_front());
         n_popped++;
      end
      if (m_push) begin
         sb.push_back(id);
      end
      m_mem_count = m_mem_count + int'(m_push) - int'(m_read);
      if (m_read) begin
         m_out_valid = 1'b1;
      end else if (m_pop) begin
         m_out_valid = 1'b0;
      end
      accepted = m_push;
      @(posedge clk);
      #1;
   endtask

   // Drain everything with out_ready held, bounded by a cycle budget.
   task automatic drain(input string tag);
      logic acc;
      int   cyc;
      cyc = 0;
      while ((sb.size() > 0) && (cyc < 4 * ELEMENTS)) begin
         apply_stimulus(1'b0, '0, 1'b1, acc);
         cyc++;
      end
      check_output(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic acc;
      int   next_data;
      int   popped_before;
      bit   done;

      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      n_popped  = 0;
      apply_reset(1'b0, '0, 1'b0);
      apply_reset(1'b0, '0, 1'b0);

      $display("[TB] reset state");
      check_output("reset_in_ready", 32'(in_ready), 32'd1);
      check_output("reset_out_valid", 32'(out_valid), 32'd0);
      check_output("reset_count", 32'(count), 32'd0);

      $display("[TB] single entry latency");
      apply_stimulus(1'b1, 32'hA5A5A5A5, 1'b1, acc);
      check_output("lat_n1_count", 32'(count), 32'd1);
      check_output("lat_n1_out_valid", 32'(out_valid), 32'd0);
      apply_stimulus(1'b0, '0, 1'b1, acc);
      check_output("lat_n2_out_valid", 32'(out_valid), 32'd1);
      check_output("lat_n2_out_data", out_data, 32'hA5A5A5A5);
      check_output("lat_n2_count", 32'(count), 32'd1);
      apply_stimulus(1'b0, '0, 1'b1, acc);
      check_output("lat_after_pop_count", 32'(count), 32'd0);

      $display("[TB] fill to capacity");
      for (int i = 1; i <= ELEMENTS + 1; i++) begin
         apply_stimulus(1'b1, WIDTH'(i), 1'b0, acc);
         check_output("fill_accept", 32'(acc), 32'd1);
      end
      check_output("full_in_ready", 32'(in_ready), 32'd0);
      check_output("full_count", 32'(count), 32'(ELEMENTS + 1));
      apply_stimulus(1'b1, 32'd18, 1'b0, acc);
      check_output("full_ignore_count", 32'(count), 32'(ELEMENTS + 1));
      check_output("full_ignore_out_data", out_data, 32'd1);
      apply_stimulus(1'b0, '0, 1'b1, acc);
      check_output("after_pop_in_ready", 32'(in_ready), 32'd1);
      apply_stimulus(1'b1, 32'd18, 1'b0, acc);
      check_output("refill_accept", 32'(acc), 32'd1);
      check_output("refill_count", 32'(count), 32'(ELEMENTS + 1));
      drain("fill_drain");

      $display("[TB] random streaming with wrap-around");
      next_data     = 0;
      popped_before = n_popped;
      done          = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         apply_stimulus((next_data < 100) && ($urandom_range(0, 3) != 0), WIDTH'(next_data),
                        ($urandom_range(0, 2) != 0), acc);
         if (acc) begin
            next_data++;
         end
         done = (next_data == 100) && (sb.size() == 0);
      end
      check_output("stream_done", 32'(done), 32'd1);
      check_output("stream_popped", 32'(n_popped - popped_before), 32'd100);

      $display("[TB] reset mid-operation");
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, WIDTH'(32'h100 + i), 1'b0, acc);
      end
      check_output("five_count", 32'(count), 32'd5);
      apply_reset(1'b1, 32'hDEADBEEF, 1'b1);
      check_output("midrst_count", 32'(count), 32'd0);
      check_output("midrst_out_valid", 32'(out_valid), 32'd0);
      check_output("midrst_in_ready", 32'(in_ready), 32'd1);
      apply_stimulus(1'b1, 32'h1, 1'b1, acc);
      apply_stimulus(1'b0, '0, 1'b1, acc);
      check_output("post_rst_out_valid", 32'(out_valid), 32'd1);
      check_output("post_rst_out_data", out_data, 32'h1);
      apply_stimulus(1'b0, '0, 1'b1, acc);
      check_output("post_rst_empty", 32'(count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_armleocpu_mem_fifo
